serializer: RTL

SERIALIZER -- requirements
Module: serializer

---
 rtl/serial_pkg.sv | 13 +
 rtl/serializer_if.sv | 25 ++
 rtl/serializer.sv | 88 ++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types for the byte serializer: FSM state encoding and counter sizing helper.
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE,
    SEND
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serializer_if.sv
// Word-in / byte-out handshake bundle; slave is the serializer's view, master the driver's.
interface serializer_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_WORDS = 4
);

  logic [WIDTH*NUM_WORDS-1:0] i_data;
  logic                       i_dv;
  logic                       o_ready;
  logic [WIDTH-1:0]           o_data;
  logic                       o_dv;
  logic                       i_ready;
  logic                       o_busy;

  modport slave (
    input  i_data, i_dv, i_ready,
    output o_ready, o_data, o_dv, o_busy
  );

  modport master (
    output i_data, i_dv, i_ready,
    input  o_ready, o_data, o_dv, o_busy
  );

endinterface

// File: rtl/serializer.sv
// Parallel word to byte-stream serializer with zero-bubble back-to-back words.
// Define SERIALIZER_DBUF_EN to add a one-word holding buffer that accepts during SEND.
module serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_WORDS     = 4,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic         clk,
  input  logic         i_reset,
  serializer_if.slave  bus
);

  localparam int unsigned WordW = WIDTH * NUM_WORDS;
  localparam int unsigned CntW  = cnt_width(NUM_WORDS);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_WORDS - 1);

  state_e            state_q;
  logic [WordW-1:0]  sreg_q;
  logic [CntW-1:0]   cnt_q;
  logic              dv_q;

  logic              consume;
  logic              last_consume;
  logic              load;
  logic [WordW-1:0]  load_word;

  assign consume      = dv_q && bus.i_ready;
  assign last_consume = consume && (cnt_q == LastIdx);

`ifdef SERIALIZER_DBUF_EN
  logic [WordW-1:0]  buf_q;
  logic              buf_vld_q;
  logic              accept;
  logic              direct;

  assign bus.o_ready = i_reset && !buf_vld_q;
  assign accept      = bus.i_dv && bus.o_ready;
  // A word goes straight to the shift register when nothing is left to send after this cycle.
  assign direct      = accept && ((state_q == IDLE) || last_consume);
  assign load        = direct || (buf_vld_q && last_consume);
  assign load_word   = buf_vld_q ? buf_q : bus.i_data;
  assign bus.o_busy  = (state_q == SEND) || buf_vld_q;

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
    end else if (accept && !direct) begin
      buf_q     <= bus.i_data;
      buf_vld_q <= 1'b1;
    end else if (buf_vld_q && last_consume) begin
      buf_vld_q <= 1'b0;
    end
  end
`else
  assign bus.o_ready = i_reset && ((state_q == IDLE) || last_consume);
  assign load        = bus.i_dv && bus.o_ready;
  assign load_word   = bus.i_data;
  assign bus.o_busy  = (state_q == SEND);
`endif

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
    end else if (load) begin
      state_q <= SEND;
      sreg_q  <= load_word;
      cnt_q   <= '0;
      dv_q    <= 1'b1;
    end else if (last_consume) begin
      state_q <= IDLE;
      dv_q    <= 1'b0;
    end else if (consume) begin
      cnt_q  <= cnt_q + CntW'(1);
      sreg_q <= LITTLE_ENDIAN ? (sreg_q >> WIDTH) : (sreg_q << WIDTH);
    end
  end

  // Current byte always sits at the end the shift register drains from.
  assign bus.o_data = LITTLE_ENDIAN ? sreg_q[WIDTH-1:0] : sreg_q[WordW-1 -: WIDTH];
  assign bus.o_dv   = dv_q;

endmodule
